sram: RTL and testbench
=======================

# sram

Generic single-port synchronous SRAM with a registered read output. It is used as a small on-chip storage primitive (register files, buffers, lookup tables) wherever a one-cycle-latency read/write memory is needed. One access per clock, either a read or a write, selected by `rw` and gated by `en`.

## Interface
Parameters:
- `SIZE`, default 16: number of words; must be ≥ 2.
- `DATA_WIDTH`, default 4: bits per word; must be ≥ 1.

Address width is `AW = $clog2(SIZE)`.

Ports:
- `clk`  input  1: single clock; all state changes on the rising edge.
- `rst`  input  1: reset, synchronous and active-high.
- `en`  input  1: access enable; 0 means no access this cycle.
- `rw`  input  1: access type when `en`=1; 1 = write, 0 = read.
- `addr`  input  AW: word address.
- `in`  input  DATA_WIDTH: write data.
- `out`  output  DATA_WIDTH: registered read data.

## Operation
- Storage: `SIZE` words of `DATA_WIDTH` bits each, plus an output register `out`.
- Reset (`rst`=1 at a rising edge):
  - `out` is set to 0.
  - Every memory word is cleared to 0.
  - `en`, `rw`, `addr` and `in` are ignored while `rst` is high.
- Write (`rst`=0, `en`=1, `rw`=1): `mem[addr] <= in`. `out` holds its previous value; there is no write-through.
- Read (`rst`=0, `en`=1, `rw`=0): `out <= mem[addr]`.
- Idle (`rst`=0, `en`=0): memory and `out` are unchanged.
- Out-of-range address (`addr` ≥ `SIZE`, possible only when `SIZE` is not a power of 2):
  - A write is ignored.
  - A read loads 0 into `out`.
- Priority: `rst` > `en` > `rw`.
- No handshake; an access is accepted on every enabled cycle.
- The block has no FSM.

## Timing
- Read latency: 1 cycle. Data addressed at rising edge N appears on `out` just after edge N and is stable until the next edge that performs a read or reset.
- Write latency: 1 cycle.
  - A write at edge N is visible to a read issued at edge N+1.
  - That read's data appears on `out` after edge N+1.
- `out` is a pure register output, with no combinational path from any input.
- Reset takes effect at the first rising edge with `rst`=1.
  - After that edge, `out` = 0 and all words = 0.
  - A read of any address in the first enabled cycle after reset returns 0.
- Reset mid-operation: a pending access in the same cycle as `rst`=1 is discarded. No partial write occurs.
- Back-to-back access:
  - Consecutive reads to different addresses return one word per cycle.
  - Alternating write/read to the same address returns the newly written data.
- Inputs must be stable around the rising edge (standard setup/hold). There is no internal input register.

## Test plan
- Reset then read: `rst`=1 for 1 cycle, then `en`=1, `rw`=0, `addr`=0 -> `out`=0 one cycle later.
- Write then read: `en`=1, `rw`=1, `addr`=0, `in`=1 for one cycle -> `out` unchanged that cycle; then `rw`=0, `addr`=0 -> `out`=1 after the next edge.
- Full sweep: write `mem[i]=i` for i=0..15, then read 0..15 back-to-back -> `out` = 0,1,...,15 with 1-cycle latency, one per cycle.
- Enable gating:
  - Set `out`=5 via a read.
  - Drive `en`=0 with `rw`=1, `in`=F, `addr`=3 for several cycles -> `out` stays 5.
  - A later read of address 3 returns the previously stored value, not F.
- Reset clears contents:
  - Fill all words with A.
  - Assert `rst` for 1 cycle concurrently with a write of 7 to `addr` 2.
  - Read all addresses -> all 0; `addr` 2 is not 7.
- Non-power-of-2 `SIZE`=12:
  - Write 9 to `addr` 13, then read `addr` 13 -> `out`=0.
  - `mem[0..11]` is unaffected.

Source files
------------

// File: rtl/sram.sv
// Single-port synchronous SRAM with a registered read port. Reset clears the
// output register and every stored word; out-of-range accesses are harmless.
module sram #(
   parameter int SIZE       = 16,
   parameter int DATA_WIDTH = 4,
   localparam int AW        = $clog2(SIZE)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  rw,
   input  logic [AW-1:0]         addr,
   input  logic [DATA_WIDTH-1:0] in,
   output logic [DATA_WIDTH-1:0] out
);

   logic [DATA_WIDTH-1:0] mem [SIZE];
   logic                  addr_ok;

   // Only non-power-of-2 depths can see an address past the last word.
   generate
      if ((1 << AW) == SIZE) begin : g_full_range
         assign addr_ok = 1'b1;
      end else begin : g_partial_range
         assign addr_ok = ({1'b0, addr} < (AW+1)'(SIZE));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         out <= '0;
         for (int i = 0; i < SIZE; i++) begin
            mem[i] <= '0;
         end
      end else if (en) begin
         if (rw) begin
            if (addr_ok) begin
               mem[addr] <= in;
            end
         end else begin
            out <= addr_ok ? mem[addr] : '0;
         end
      end
   end

endmodule

// File: tb/tb_sram.sv
// Self-checking bench for sram: a power-of-2 instance and a SIZE=12 instance
// share one stimulus stream and are checked every cycle against an array model.
module tb_sram;

   logic       clk;
   logic       rst;
   logic       en;
   logic       rw;
   logic [3:0] addr;
   logic [3:0] in;
   logic [3:0] out16;
   logic [3:0] out12;

   int   compared   = 0;
   int   mismatched = 0;
   bit   modelValid = 0;

   int   mem16 [16];
   int   mem12 [12];
   int   exp16;
   int   exp12;

   sram #(.SIZE(16), .DATA_WIDTH(4)) dut16 (
      .clk(clk), .rst(rst), .en(en), .rw(rw), .addr(addr), .in(in), .out(out16)
   );

   sram #(.SIZE(12), .DATA_WIDTH(4)) dut12 (
      .clk(clk), .rst(rst), .en(en), .rw(rw), .addr(addr), .in(in), .out(out12)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference behaviour: plain arrays updated from the memory's access rules.
   always @(posedge clk) begin
      if (rst) begin
         foreach (mem16[i]) mem16[i] = 0;
         foreach (mem12[i]) mem12[i] = 0;
         exp16 = 0;
         exp12 = 0;
         modelValid = 1'b1;
      end else if (en) begin
         if (rw) begin
            mem16[addr] = int'(in);
            if (int'(addr) < 12) mem12[addr] = int'(in);
         end else begin
            exp16 = mem16[addr];
            exp12 = (int'(addr) < 12) ? mem12[addr] : 0;
         end
      end
   end

   always @(negedge clk) begin
      if (modelValid) begin
         compared += 2;
         if (int'(out16) != exp16) begin
            mismatched++;
            $display("[TB] FAIL model16 t=%0t out=%0d expected=%0d", $time, out16, exp16);
         end
         if (int'(out12) != exp12) begin
            mismatched++;
            $display("[TB] FAIL model12 t=%0t out=%0d expected=%0d", $time, out12, exp12);
         end
      end
   end

   task automatic applyStimulus(input logic r, input logic e, input logic w,
                                input logic [3:0] a, input logic [3:0] d);
      rst  = r;
      en   = e;
      rw   = w;
      addr = a;
      in   = d;
      @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input logic [3:0] actual,
                              input int expected);
      compared++;
      if (int'(actual) != expected) begin
         mismatched++;
         $display("[TB] FAIL %s out=%0d expected=%0d", name, actual, expected);
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; rw = 1'b0; addr = '0; in = '0;
      @(negedge clk);

      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("resetRead", out16, 0);

      applyStimulus(0, 1, 1, 0, 1);
      checkOutput("noWriteThrough", out16, 0);
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("writeThenRead", out16, 1);

      for (int i = 0; i < 16; i++) applyStimulus(0, 1, 1, 4'(i), 4'(i));
      for (int i = 0; i < 16; i++) begin
         applyStimulus(0, 1, 0, 4'(i), 4'(0));
         checkOutput("sweep16", out16, i);
         checkOutput("sweep12", out12, (i < 12) ? i : 0);
      end

      applyStimulus(0, 1, 0, 5, 0);
      checkOutput("gateSetup", out16, 5);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0, 1, 3, 4'hF);
         checkOutput("gateHold", out16, 5);
      end
      applyStimulus(0, 1, 0, 3, 0);
      checkOutput("gateNoWrite", out16, 3);

      for (int i = 0; i < 16; i++) applyStimulus(0, 1, 1, 4'(i), 4'hA);
      applyStimulus(0, 1, 0, 2, 0);
      checkOutput("fillA", out16, 10);
      applyStimulus(1, 1, 1, 2, 7);
      checkOutput("resetOut", out16, 0);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(0, 1, 0, 4'(i), 0);
         checkOutput("resetClears", out16, 0);
      end

      for (int i = 0; i < 12; i++) applyStimulus(0, 1, 1, 4'(i), 4'(i + 3));
      applyStimulus(0, 1, 1, 13, 9);
      applyStimulus(0, 1, 0, 13, 0);
      checkOutput("oorRead12", out12, 0);
      checkOutput("inRange16", out16, 9);
      for (int i = 0; i < 12; i++) begin
         applyStimulus(0, 1, 0, 4'(i), 0);
         checkOutput("oorNoAlias", out12, (i + 3) % 16);
      end

      for (int i = 0; i < 3000; i++) begin
         applyStimulus(($urandom_range(63) == 0),
                       ($urandom_range(3) != 0),
                       1'($urandom_range(1)),
                       4'($urandom_range(15)),
                       4'($urandom_range(15)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
